// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use stall, branch flush, EX forwarding and WB bypass control
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NSTAGES  = 3,
  parameter int ZERO_REG = 31,
  parameter int LD_FWD   = 2,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rn,
  input  logic [REG_AW-1:0]          id_rm,
  input  logic                       id_rn_used,
  input  logic                       id_rm_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       br_taken,
  output logic                       pc_en,
  output logic                       ifid_en,
  output logic                       ifid_flush,
  output logic                       idex_bubble,
  output logic [$clog2(NSTAGES)-1:0] fwd_a,
  output logic [$clog2(NSTAGES)-1:0] fwd_b,
  output logic                       wb_byp_a,
  output logic                       wb_byp_b,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int                FW = $clog2(NSTAGES);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  // In-flight tracking, entry 0 = ID_EX. The oldest entry's memread is
  // never consulted (loads there are always forwardable), so it is not kept.
  logic [NSTAGES-1:0] v_q, v_d, rw_q, rw_d;
  logic [NSTAGES-2:0] mr_q, mr_d;
  logic [REG_AW-1:0]  rd_q [NSTAGES];
  logic [REG_AW-1:0]  rd_d [NSTAGES];
  logic [REG_AW-1:0]  ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d;
  logic               ex_rn_used_q, ex_rn_used_d, ex_rm_used_q, ex_rm_used_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic               load_use, flush, stall;

  function automatic logic producer(input logic v, input logic rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] r);
    return v & rw & (rd == r) & (r != ZR);
  endfunction

  // Hazard detection and pipeline enables; a taken branch outranks a stall
  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < LD_FWD - 1; k++) begin
      load_use = load_use | (mr_q[k] &
                 ((id_rn_used & producer(v_q[k], rw_q[k], rd_q[k], id_rn)) |
                  (id_rm_used & producer(v_q[k], rw_q[k], rd_q[k], id_rm))));
    end
    load_use    = load_use & id_valid;
    flush       = br_taken & v_q[BR_STAGE];
    stall       = load_use & ~flush;
    pc_en       = ~stall;
    ifid_en     = ~stall;
    ifid_flush  = flush;
    idex_bubble = flush | load_use;
  end

  // EX forwarding: scan oldest to youngest so the youngest producer is left selected
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = NSTAGES - 1; k >= 1; k--) begin
      if (ex_rn_used_q & producer(v_q[k], rw_q[k], rd_q[k], ex_rn_q)) fwd_a = FW'(k);
      if (ex_rm_used_q & producer(v_q[k], rw_q[k], rd_q[k], ex_rm_q)) fwd_b = FW'(k);
    end
    wb_byp_a = id_rn_used & producer(v_q[NSTAGES-1], rw_q[NSTAGES-1], rd_q[NSTAGES-1], id_rn);
    wb_byp_b = id_rm_used & producer(v_q[NSTAGES-1], rw_q[NSTAGES-1], rd_q[NSTAGES-1], id_rm);
  end

  // Next state: shift tracking down one entry, kill wrong-path entries, bump counters
  always_comb begin
    v_d[0]  = id_valid & ~idex_bubble;
    rw_d[0] = id_regwrite;
    mr_d[0] = id_memread;
    rd_d[0] = id_rd;
    for (int k = 1; k < NSTAGES; k++) begin
      v_d[k]  = v_q[k-1] & ~(flush & (k <= BR_STAGE));
      rw_d[k] = rw_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    for (int k = 1; k < NSTAGES - 1; k++) begin
      mr_d[k] = mr_q[k-1];
    end
    ex_rn_d      = id_rn;
    ex_rm_d      = id_rm;
    ex_rn_used_d = id_rn_used & id_valid & ~idex_bubble;
    ex_rm_used_d = id_rm_used & id_valid & ~idex_bubble;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers; reset empties the pipeline tracking at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q          <= '0;
      rw_q         <= '0;
      mr_q         <= '0;
      for (int k = 0; k < NSTAGES; k++) rd_q[k] <= '0;
      ex_rn_q      <= '0;
      ex_rm_q      <= '0;
      ex_rn_used_q <= 1'b0;
      ex_rm_used_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      v_q          <= v_d;
      rw_q         <= rw_d;
      mr_q         <= mr_d;
      for (int k = 0; k < NSTAGES; k++) rd_q[k] <= rd_d[k];
      ex_rn_q      <= ex_rn_d;
      ex_rm_q      <= ex_rm_d;
      ex_rn_used_q <= ex_rn_used_d;
      ex_rm_used_q <= ex_rm_used_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit
module tb_pipe_hazard_unit;
  localparam int AW = 5, NS = 3, ZR = 31, LDF = 2, BRS = 1, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 0, id_rn_used = 0, id_rm_used = 0, id_regwrite = 0, id_memread = 0, br_taken = 0;
  logic [AW-1:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, wb_byp_a, wb_byp_b;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_unit #(.REG_AW(AW), .NSTAGES(NS), .ZERO_REG(ZR), .LD_FWD(LDF),
                     .BR_STAGE(BRS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_byp_a(wb_byp_a), .wb_byp_b(wb_byp_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, wb_a, wb_b, scnt, fcnt;
    bit ldmask [NS];
  } exp_t;
  exp_t sb[$];

  typedef struct { bit v; int rd; bit rw; bit mr; } ent_t;
  ent_t pipe [NS];
  int   ex_rn, ex_rm, m_scnt, m_fcnt;
  bit   ex_rnu, ex_rmu;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit prod(int k, int r);
    return pipe[k].v && pipe[k].rw && pipe[k].rd == r && r != ZR;
  endfunction

  function automatic int youngest(bit used, int r);
    if (!used) return 0;
    for (int k = 1; k < NS; k++) if (prod(k, r)) return k;
    return 0;
  endfunction

  // one ID cycle: drive, predict from the instruction-level model, then advance the model
  task automatic issue(bit rs, bit v, int rn, bit rnu, int rm, bit rmu, int rd, bit rw, bit mr, bit br);
    exp_t e;
    bit lu, fl;
    ent_t nxt [NS];
    @(negedge clk); #1;
    rst = rs; id_valid = v; id_rn = 5'(rn); id_rm = 5'(rm); id_rn_used = rnu; id_rm_used = rmu;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr; br_taken = br;
    if (!rs) begin
      foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
      ex_rnu = 0; ex_rmu = 0; m_scnt = 0; m_fcnt = 0;
    end
    lu = 0;
    for (int k = 0; k < NS; k++)
      if (k + 1 < LDF && pipe[k].mr && ((rnu && prod(k, rn)) || (rmu && prod(k, rm)))) lu = v;
    fl = br && pipe[BRS].v;
    e.ifid_flush = fl;
    e.idex_bubble = fl || lu;
    e.pc_en = !(lu && !fl);
    e.ifid_en = e.pc_en;
    e.fwd_a = youngest(ex_rnu, ex_rn);
    e.fwd_b = youngest(ex_rmu, ex_rm);
    e.wb_a = rnu && prod(NS - 1, rn);
    e.wb_b = rmu && prod(NS - 1, rm);
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    for (int k = 0; k < NS; k++) e.ldmask[k] = pipe[k].v && pipe[k].mr && k < LDF;
    sb.push_back(e);
    if (rs) begin
      nxt[0] = '{v && !(fl || lu), rd, rw, mr};
      for (int k = 1; k < NS; k++) begin
        nxt[k] = pipe[k-1];
        if (fl && k <= BRS) nxt[k].v = 0;
      end
      pipe = nxt;
      ex_rn = rn; ex_rm = rm;
      ex_rnu = rnu && nxt[0].v; ex_rmu = rmu && nxt[0].v;
      if (lu && !fl && m_scnt < CMAX) m_scnt++;
      if (fl && m_fcnt < CMAX) m_fcnt++;
    end
  endtask

  task automatic nop();                      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ins(int rd, int rn, int rm, bit rw, bit mr, bit br);
    issue(1, 1, rn, 1, rm, 1, rd, rw, mr, br);
  endtask

  // monitor: compare DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_en", pc_en, e.pc_en);
        chk("ifid_en", ifid_en, e.ifid_en);
        chk("ifid_flush", ifid_flush, e.ifid_flush);
        chk("idex_bubble", idex_bubble, e.idex_bubble);
        chk("fwd_a", fwd_a, e.fwd_a);
        chk("fwd_b", fwd_b, e.fwd_b);
        chk("wb_byp_a", wb_byp_a, e.wb_a);
        chk("wb_byp_b", wb_byp_b, e.wb_b);
        chk("stall_cnt", stall_cnt, e.scnt);
        chk("flush_cnt", flush_cnt, e.fcnt);
        chk("ld_fwd_too_early", (fwd_a != 0 && e.ldmask[fwd_a]) || (fwd_b != 0 && e.ldmask[fwd_b]), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    // reset and idle
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) begin nop(); #2; chk("idle_fwd_a", fwd_a, 0); chk("idle_pc_en", pc_en, 1); end
    // ALU chain
    ins(1, 10, 11, 1, 0, 0);
    ins(2, 1, 3, 1, 0, 0);
    ins(4, 1, 1, 1, 0, 0); #2; chk("chain_sub_fwd_a", fwd_a, 1); chk("chain_sub_fwd_b", fwd_b, 0);
    nop(); #2; chk("chain_orr_fwd_a", fwd_a, 2); chk("chain_orr_fwd_b", fwd_b, 2);
    chk("chain_stall_cnt", stall_cnt, 0);
    // double producer
    ins(1, 10, 11, 1, 0, 0);
    ins(1, 12, 13, 1, 0, 0);
    ins(5, 1, 14, 1, 0, 0);
    nop(); #2; chk("double_fwd_a", fwd_a, 1);
    repeat (3) nop();
    // load-use
    ins(1, 10, 11, 1, 1, 0);
    ins(2, 1, 1, 1, 0, 0); #2;
    chk("lu_pc_en", pc_en, 0); chk("lu_ifid_en", ifid_en, 0); chk("lu_bubble", idex_bubble, 1);
    ins(2, 1, 1, 1, 0, 0); #2; chk("lu_replay_pc_en", pc_en, 1);
    nop(); #2; chk("lu_fwd_a", fwd_a, 2); chk("lu_fwd_b", fwd_b, 2); chk("lu_stall_cnt", stall_cnt, 1);
    repeat (3) nop();
    // load-use on the zero register
    ins(31, 10, 11, 1, 1, 0);
    ins(2, 31, 31, 1, 0, 0); #2; chk("xzr_pc_en", pc_en, 1); chk("xzr_bubble", idex_bubble, 0);
    repeat (3) nop();
    // branch flush beats a simultaneous load-use stall
    ins(0, 20, 21, 0, 0, 0);
    ins(9, 10, 11, 1, 1, 0);
    ins(2, 9, 9, 1, 0, 1); #2;
    chk("br_flush", ifid_flush, 1); chk("br_bubble", idex_bubble, 1); chk("br_pc_en", pc_en, 1);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("br_ignored", ifid_flush, 0); chk("br_flush_cnt", flush_cnt, 1); chk("br_stall_cnt", stall_cnt, 1);
    repeat (3) nop();
    // write-through bypass
    ins(7, 10, 11, 1, 0, 0);
    nop(); nop();
    ins(3, 7, 12, 1, 0, 0); #2; chk("wb_byp_a_x7", wb_byp_a, 1);
    // stall counter saturation
    repeat (20) begin ins(1, 10, 11, 1, 1, 0); ins(2, 1, 1, 1, 0, 0); end
    nop(); #2; chk("sat_stall_cnt", stall_cnt, 15);
    // reset mid-run with entries in flight
    ins(1, 10, 11, 1, 1, 0);
    issue(0, 1, 1, 1, 1, 1, 2, 1, 0, 1); #2;
    chk("rst_stall_cnt", stall_cnt, 0); chk("rst_pc_en", pc_en, 1); chk("rst_flush", ifid_flush, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) begin nop(); #2; chk("post_rst_fwd_b", fwd_b, 0); chk("post_rst_bubble", idex_bubble, 0); end
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int rn, rm, rd;
      rn = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 6);
      rm = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 6);
      rd = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 6);
      s = $urandom_range(0, 99);
      issue(s != 0, $urandom_range(0, 9) < 8, rn, $urandom_range(0, 3) != 0, rm,
            $urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end
    nop();
    @(negedge clk); #5;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard and pipeline-control unit for the in-order pipelined CPU. It tracks in-flight destination registers after ID in an internal shift register and drives these controls:
- EX-stage forwarding selects and ID-stage write-through bypass.
- Load-use stalls (PC/IF_ID hold plus ID_EX bubble) and branch-taken flushes.
- Saturating stall and flush performance counters.

It generalises the existing fixed 3-source forwarding logic to NSTAGES tracked stages, a configurable load-forward point and a configurable branch-resolve stage.

Parameters:
REG_AW, 5, register address width
NSTAGES, 3, tracked post-ID entries (0=ID_EX, 1=EX_MEM, 2=MEM_WB); legal range 2..8
ZERO_REG, 31, register never treated as a hazard (XZR)
LD_FWD, 2, lowest entry index from which load data is forwardable; range 1..NSTAGES-1
BR_STAGE, 1, entry index where a branch resolves; range 0..NSTAGES-1
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rn  in  REG_AW  ID source A
id_rm  in  REG_AW  ID source B
id_rn_used  in  1  source A read
id_rm_used  in  1  source B read
id_rd  in  REG_AW  ID destination
id_regwrite  in  1  ID writes rd
id_memread  in  1  ID is a load
br_taken  in  1  branch at entry BR_STAGE taken
pc_en  out  1  PC write enable
ifid_en  out  1  IF_ID enable
ifid_flush  out  1  clear IF_ID to NOP next edge
idex_bubble  out  1  load NOP into ID_EX next edge
fwd_a  out  $clog2(NSTAGES)  EX operand A source: 0=register file, k=entry k (1..NSTAGES-1)
fwd_b  out  $clog2(NSTAGES)  EX operand B source, same encoding as fwd_a
wb_byp_a  out  1  ID source A takes write-back data
wb_byp_b  out  1  ID source B takes write-back data
stall_cnt  out  CNT_W  stall cycles
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- State:
  - entry[k] = {valid, rd, regwrite, memread}, k=0..NSTAGES-1.
  - EX source regs ex_rn/ex_rm with their used bits.
  - Both counters.
- "Producer k matches r": entry[k].valid & entry[k].regwrite & entry[k].rd==r & r!=ZERO_REG.
- Reset (rst=0, async): all valid=0, ex_*_used=0, counters=0.
- Outputs while in reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=0, wb_byp_a=wb_byp_b=0.
- Load-use hazard (combinational):
  - Condition: id_valid, and a used ID source matches producer k with entry[k].memread, for some k with k+1 < LD_FWD.
  - Default LD_FWD=2 gives k=0 only, i.e. exactly a 1-cycle load-use stall.
- Flush (combinational): br_taken & entry[BR_STAGE].valid. br_taken is ignored when that entry is invalid.
- Priority: flush overrides stall.
  - Flush: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1.
  - Stall: pc_en=0, ifid_en=0, idex_bubble=1.
  - Otherwise: all enables 1, no flush, no bubble.
- Shift on every clock edge:
  - entry[k] <= entry[k-1] for k>=1; entry[NSTAGES-1] retires.
  - entry[0] <= ID fields, or valid=0 when idex_bubble or !id_valid.
  - On flush, entries 1..BR_STAGE (younger than the branch after shifting) load valid=0. The branch itself proceeds.
  - ex_rn/ex_rm follow entry[0] and load used=0 when a bubble is inserted.
- Forwarding (combinational, from state):
  - fwd_a = smallest k in 1..NSTAGES-1 such that ex_rn_used and producer k matches ex_rn; 0 if none. Youngest producer wins.
  - fwd_b: same rule using ex_rm.
  - A matching load producer with k < LD_FWD is impossible by construction. The verifier asserts this never occurs.
- Write-through: wb_byp_a = id_rn_used & producer NSTAGES-1 matches id_rn; wb_byp_b the same for id_rm. Asserted even during stall.
- Counters:
  - stall_cnt +1 on each edge where the stall condition holds and flush does not.
  - flush_cnt +1 on each flush edge.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation discards all in-flight tracking immediately; the next edge after release starts from the empty state.

Test Plan:
- Reset/idle: assert rst=0 mid-run with entries valid -> all outputs at reset values, counters 0; release, id_valid=0 for 4 cycles -> fwd_a=fwd_b=0, no stall.
- ALU chain: ADD X1 then SUB X2,X1,X3 then ORR X4,X1,X1 -> SUB in EX sees fwd_a=1; ORR in EX sees fwd_a=fwd_b=2; stall_cnt stays 0.
- Double producer: ADD X1; ADD X1; ADD X5,X1 -> fwd_a=1 (youngest) on X5's EX cycle.
- Load-use: LDUR X1 then ADD X2,X1,X1 -> exactly one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle fwd_a=fwd_b=2; stall_cnt=1. Same sequence targeting X31 -> no stall.
- Branch flush: taken branch reaches entry 1 with br_taken=1 while a load-use stall condition is present in ID -> ifid_flush=1, idex_bubble=1, pc_en=1; entry 1 invalid after the edge; flush_cnt=1, stall_cnt unchanged. br_taken=1 with entry 1 invalid -> ignored.
- Write-through and saturation: MEM_WB producer X7 while ID reads X7 -> wb_byp_a=1. With CNT_W=4 and 20 forced stalls -> stall_cnt holds at 15.
